chacha_xor_stream: RTL and testbench

- Byte-serial ChaCha20 encrypt/decrypt engine: XORs a plaintext/ciphertext byte stream with the keystream.
- Sits downstream of the chacha_BLOCK keystream generator and drives its start/counter interface, one 64-byte block at a time.
- Buffers each 64-byte keystream block and auto-increments the block counter between blocks.
- Presents valid/ready byte streams on both data sides.

---
 rtl/chacha_pkg.sv | 21 ++
 rtl/chacha_ks_buf.sv | 57 +++++
 rtl/chacha_xor_stream.sv | 137 +++++++++++++
 tb/tb_chacha_xor_stream.sv | 479 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chacha_pkg.sv
// rtl/chacha_pkg.sv - shared widths, buffer index width and FSM encoding for the ChaCha20 XOR stream
package chacha_pkg;

  localparam int BLOCK_BYTES = 64;
  localparam int KEY_W       = 256;
  localparam int NONCE_W     = 96;
  localparam int CTR_W       = 32;
  localparam int IDX_W       = $clog2(BLOCK_BYTES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    FILL   = 2'd2,
    STREAM = 2'd3
  } state_t;

  function automatic logic is_last_idx(input logic [IDX_W-1:0] idx);
    return idx == IDX_W'(BLOCK_BYTES - 1);
  endfunction

endpackage

// File: rtl/chacha_ks_buf.sv
// rtl/chacha_ks_buf.sv - 64x8 keystream block buffer with write/read indices and full/last flags
module chacha_ks_buf
  import chacha_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       wr_clr_i,
  input  logic       wr_en_i,
  input  logic [7:0] wr_data_i,
  input  logic       rd_clr_i,
  input  logic       rd_en_i,
  output logic [7:0] rd_data_o,
  output logic       full_o,
  output logic       wr_last_o,
  output logic       rd_last_o
);

  logic [7:0]       mem [BLOCK_BYTES];
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign rd_data_o = mem[rd_idx];
  assign wr_last_o = is_last_idx(wr_idx);
  assign rd_last_o = is_last_idx(rd_idx);

  // Keystream storage; contents are only meaningful once full_o is set, so no reset
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem[wr_idx] <= wr_data_i;
    end
  end

  // Index counters and the block-complete flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_idx <= '0;
      rd_idx <= '0;
      full_o <= 1'b0;
    end else begin
      if (wr_clr_i) begin
        wr_idx <= '0;
        full_o <= 1'b0;
      end else if (wr_en_i) begin
        wr_idx <= wr_idx + 1'b1;
        if (wr_last_o) begin
          full_o <= 1'b1;
        end
      end
      if (rd_clr_i) begin
        rd_idx <= '0;
      end else if (rd_en_i) begin
        rd_idx <= rd_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/chacha_xor_stream.sv
// rtl/chacha_xor_stream.sv - byte-serial ChaCha20 XOR engine; CHACHA_CTR_GUARD_EN adds ctr_err_o counter-wrap guard
module chacha_xor_stream
  import chacha_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [KEY_W-1:0]   key_i,
  input  logic [NONCE_W-1:0] nonce_i,
  input  logic [CTR_W-1:0]   counter_init_i,
  input  logic               load_i,
  output logic               busy_o,
  output logic [KEY_W-1:0]   ks_key_o,
  output logic [NONCE_W-1:0] ks_nonce_o,
  output logic [CTR_W-1:0]   ks_counter_o,
  output logic               ks_start_o,
  input  logic               ks_ready_i,
  input  logic [7:0]         ks_byte_i,
  input  logic               ks_byte_valid_i,
  input  logic [7:0]         pt_data_i,
  input  logic               pt_valid_i,
  input  logic               pt_last_i,
  output logic               pt_ready_o,
  output logic [7:0]         ct_data_o,
  output logic               ct_valid_o,
  output logic               ct_last_o,
  input  logic               ct_ready_i
`ifdef CHACHA_CTR_GUARD_EN
  ,
  output logic               ctr_err_o
`endif
);

  state_t     state;
  logic       ks_fire;
  logic       ks_wr_en;
  logic       pt_fire;
  logic       buf_full;
  logic       wr_last;
  logic       rd_last;
  logic [7:0] ks_rd_byte;

  assign ks_fire    = ks_start_o & ks_ready_i;
  assign ks_wr_en   = (state == FILL) & ks_byte_valid_i;
  assign pt_ready_o = (state == STREAM) & buf_full & (~ct_valid_o | ct_ready_i);
  assign pt_fire    = pt_valid_i & pt_ready_o;
  assign busy_o     = (state != IDLE);

  chacha_ks_buf u_ks_buf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_clr_i  (ks_fire),
    .wr_en_i   (ks_wr_en),
    .wr_data_i (ks_byte_i),
    .rd_clr_i  (ks_wr_en & wr_last),
    .rd_en_i   (pt_fire),
    .rd_data_o (ks_rd_byte),
    .full_o    (buf_full),
    .wr_last_o (wr_last),
    .rd_last_o (rd_last)
  );

  // Session FSM: latch session, request a block, fill it, stream it, advance the counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      ks_start_o   <= 1'b0;
      ks_key_o     <= '0;
      ks_nonce_o   <= '0;
      ks_counter_o <= '0;
`ifdef CHACHA_CTR_GUARD_EN
      ctr_err_o    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (load_i) begin
            ks_key_o     <= key_i;
            ks_nonce_o   <= nonce_i;
            ks_counter_o <= counter_init_i;
            ks_start_o   <= 1'b1;
            state        <= REQ;
`ifdef CHACHA_CTR_GUARD_EN
            ctr_err_o    <= 1'b0;
`endif
          end
        end
        REQ: begin
          if (ks_fire) begin
            ks_start_o <= 1'b0;
            state      <= FILL;
          end
        end
        FILL: begin
          if (ks_wr_en && wr_last) begin
            state <= STREAM;
          end
        end
        STREAM: begin
          if (pt_fire) begin
            if (pt_last_i) begin
              state <= IDLE;
            end else if (rd_last) begin
`ifdef CHACHA_CTR_GUARD_EN
              if (ks_counter_o == '1) begin
                ctr_err_o <= 1'b1;
                state     <= IDLE;
              end else
`endif
              begin
                ks_counter_o <= ks_counter_o + 1'b1;
                ks_start_o   <= 1'b1;
                state        <= REQ;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Single registered output stage; drains on its own, independent of the FSM state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ct_data_o  <= 8'h00;
      ct_valid_o <= 1'b0;
      ct_last_o  <= 1'b0;
    end else if (pt_fire) begin
      ct_data_o  <= pt_data_i ^ ks_rd_byte;
      ct_valid_o <= 1'b1;
      ct_last_o  <= pt_last_i;
    end else if (ct_ready_i) begin
      ct_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_chacha_xor_stream.sv
// tb/tb_chacha_xor_stream.sv - self-checking bench for chacha_xor_stream with a ChaCha20 keystream model
module tb_chacha_xor_stream;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [255:0] key_i;
  logic [95:0]  nonce_i;
  logic [31:0]  counter_init_i;
  logic         load_i;
  logic         busy_o;
  logic [255:0] ks_key_o;
  logic [95:0]  ks_nonce_o;
  logic [31:0]  ks_counter_o;
  logic         ks_start_o;
  logic         ks_ready_i;
  logic [7:0]   ks_byte_i;
  logic         ks_byte_valid_i;
  logic [7:0]   pt_data_i;
  logic         pt_valid_i;
  logic         pt_last_i;
  logic         pt_ready_o;
  logic [7:0]   ct_data_o;
  logic         ct_valid_o;
  logic         ct_last_o;
  logic         ct_ready_i;
`ifdef CHACHA_CTR_GUARD_EN
  logic         ctr_err_o;
`endif

  always #5 clk_i = ~clk_i;

  chacha_xor_stream dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .key_i           (key_i),
    .nonce_i         (nonce_i),
    .counter_init_i  (counter_init_i),
    .load_i          (load_i),
    .busy_o          (busy_o),
    .ks_key_o        (ks_key_o),
    .ks_nonce_o      (ks_nonce_o),
    .ks_counter_o    (ks_counter_o),
    .ks_start_o      (ks_start_o),
    .ks_ready_i      (ks_ready_i),
    .ks_byte_i       (ks_byte_i),
    .ks_byte_valid_i (ks_byte_valid_i),
    .pt_data_i       (pt_data_i),
    .pt_valid_i      (pt_valid_i),
    .pt_last_i       (pt_last_i),
    .pt_ready_o      (pt_ready_o),
    .ct_data_o       (ct_data_o),
    .ct_valid_o      (ct_valid_o),
    .ct_last_o       (ct_last_o),
    .ct_ready_i      (ct_ready_i)
`ifdef CHACHA_CTR_GUARD_EN
    ,
    .ctr_err_o       (ctr_err_o)
`endif
  );

  int checks   = 0;
  int failures = 0;
  int stall_err = 0;
  int rdy_err   = 0;

  logic [31:0]  req_ctr [$];
  logic [7:0]   msg [$];
  logic [8:0]   got [$];

  bit           gen_busy  = 1'b0;
  bit           gen_kill  = 1'b0;
  int           gen_pos   = 0;
  int           gen_limit = 64;
  logic [511:0] gen_blk;

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [127:0] qr(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c, input logic [31:0] d);
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
    return {a, b, c, d};
  endfunction

  // ChaCha20 block function; byte i of the serialized keystream is at [8i +: 8]
  function automatic logic [511:0] chacha_block(input logic [255:0] k, input logic [95:0] n,
                                                input logic [31:0] c);
    logic [31:0]  s [16];
    logic [31:0]  x [16];
    logic [511:0] r;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int j = 0; j < 8; j++) s[4+j] = k[32*j +: 32];
    s[12] = c;
    for (int j = 0; j < 3; j++) s[13+j] = n[32*j +: 32];
    x = s;
    for (int rnd = 0; rnd < 10; rnd++) begin
      {x[0], x[4], x[8],  x[12]} = qr(x[0], x[4], x[8],  x[12]);
      {x[1], x[5], x[9],  x[13]} = qr(x[1], x[5], x[9],  x[13]);
      {x[2], x[6], x[10], x[14]} = qr(x[2], x[6], x[10], x[14]);
      {x[3], x[7], x[11], x[15]} = qr(x[3], x[7], x[11], x[15]);
      {x[0], x[5], x[10], x[15]} = qr(x[0], x[5], x[10], x[15]);
      {x[1], x[6], x[11], x[12]} = qr(x[1], x[6], x[11], x[12]);
      {x[2], x[7], x[8],  x[13]} = qr(x[2], x[7], x[8],  x[13]);
      {x[3], x[4], x[9],  x[14]} = qr(x[3], x[4], x[9],  x[14]);
    end
    for (int j = 0; j < 16; j++) r[32*j +: 32] = x[j] + s[j];
    return r;
  endfunction

  // Number of received bytes that differ from msg XOR keystream (block = byte/64 past c0)
  function automatic int count_bad(input logic [255:0] k, input logic [95:0] n,
                                   input logic [31:0] c0, input int nbytes, input int last_idx);
    int bad = 0;
    logic [511:0] blk;
    logic [8:0]   exp;
    for (int i = 0; i < nbytes; i++) begin
      blk = chacha_block(k, n, c0 + 32'(i / 64));
      exp = {(i == last_idx), msg[i] ^ blk[8*(i % 64) +: 8]};
      if (i >= got.size() || got[i] !== exp) bad++;
    end
    return bad;
  endfunction

  // Keystream generator model: accepts a request, then delivers 64 bytes with random gaps
  initial begin
    ks_ready_i = 1'b0; ks_byte_valid_i = 1'b0; ks_byte_i = 8'h00;
    forever begin
      @(negedge clk_i);
      if (gen_kill) begin
        gen_busy = 1'b0;
        gen_kill = 1'b0;
      end
      if (!gen_busy) begin
        ks_byte_valid_i = 1'b0;
        ks_ready_i = ($urandom_range(0, 3) != 0);
        if (ks_ready_i && ks_start_o && !rst_i) begin
          req_ctr.push_back(ks_counter_o);
          gen_blk  = chacha_block(ks_key_o, ks_nonce_o, ks_counter_o);
          gen_busy = 1'b1;
          gen_pos  = 0;
        end
      end else begin
        ks_ready_i = 1'b0;
        if (gen_pos < gen_limit && $urandom_range(0, 3) != 0) begin
          ks_byte_valid_i = 1'b1;
          ks_byte_i = gen_blk[8*gen_pos +: 8];
          gen_pos++;
          if (gen_pos == 64) gen_busy = 1'b0;
        end else begin
          ks_byte_valid_i = 1'b0;
        end
      end
    end
  end

  task automatic do_load(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
    @(negedge clk_i);
    key_i = k; nonce_i = n; counter_init_i = c; load_i = 1'b1;
    @(negedge clk_i);
    load_i = 1'b0;
  endtask

  // Drive msg[0..n_msg-1] and collect ct bytes until n_stop bytes were sent and received
  task automatic run_msg(input int n_msg, input int n_stop, input bit bp);
    int   idx = 0;
    int   cyc = 0;
    bit   stall_prev = 1'b0;
    bit   accepted = 1'b1;
    logic [7:0] d_prev = 8'h00;
    logic l_prev = 1'b0;
    got.delete();
    while ((idx < n_stop || got.size() < n_stop) && cyc < 20000) begin
      @(negedge clk_i);
      cyc++;
      ct_ready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (idx < n_msg) begin
        if (accepted || !pt_valid_i) pt_valid_i = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
        pt_data_i = msg[idx];
        pt_last_i = (idx == n_msg - 1);
      end else begin
        pt_valid_i = 1'b0;
        pt_last_i  = 1'b0;
      end
      #1;
      if (stall_prev && (ct_valid_o !== 1'b1 || ct_data_o !== d_prev || ct_last_o !== l_prev))
        stall_err++;
      if (pt_ready_o === 1'b1 && !(!ct_valid_o || ct_ready_i)) rdy_err++;
      if (ct_valid_o && ct_ready_i) got.push_back({ct_last_o, ct_data_o});
      accepted = pt_valid_i && pt_ready_o;
      if (accepted) idx++;
      stall_prev = ct_valid_o && !ct_ready_i;
      d_prev = ct_data_o;
      l_prev = ct_last_o;
    end
    checks++;
    if (cyc >= 20000) begin
      failures++;
      $display("FAIL run_timeout sent=%0d received=%0d required=%0d", idx, got.size(), n_stop);
    end
    @(negedge clk_i);
    pt_valid_i = 1'b0; pt_last_i = 1'b0; ct_ready_i = 1'b1;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    #1;
    checks++;
    if ({busy_o, ks_start_o, pt_ready_o, ct_valid_o, ct_last_o} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b required=00000",
               {busy_o, ks_start_o, pt_ready_o, ct_valid_o, ct_last_o});
    end
    checks++;
    if (ct_data_o !== 8'h00 || ks_counter_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_data ct=%h ctr=%h required=0", ct_data_o, ks_counter_o);
    end
    checks++;
    if (ks_key_o !== 256'h0 || ks_nonce_o !== 96'h0) begin
      failures++;
      $display("FAIL reset_key_nonce key=%h nonce=%h required=0", ks_key_o, ks_nonce_o);
    end
`ifdef CHACHA_CTR_GUARD_EN
    checks++;
    if (ctr_err_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctr_err got=%b required=0", ctr_err_o);
    end
`endif
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_rfc_vector;
    string        txt = "Ladies and Gentlemen of the class of '99: If I could offer you only one tip for the future, sunscreen would be it.";
    logic [255:0] k;
    logic [95:0]  n = 96'h0;
    logic [7:0]   exp4 [4] = '{8'h6e, 8'h2e, 8'h35, 8'h9a};
    int           bad;
    for (int i = 0; i < 32; i++) k[8*i +: 8] = 8'(i);
    n[8*7 +: 8] = 8'h4a;
    msg.delete();
    for (int i = 0; i < txt.len(); i++) msg.push_back(txt[i]);
    req_ctr.delete();
    do_load(k, n, 32'd1);
    run_msg(txt.len(), txt.len(), 1'b0);
    checks++;
    if (got.size() !== 114) begin
      failures++;
      $display("FAIL rfc_len got=%0d required=114", got.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= got.size() || got[i][7:0] !== exp4[i]) begin
        failures++;
        $display("FAIL rfc_ct_byte%0d got=%h required=%h", i, (i < got.size()) ? got[i][7:0] : 8'hxx, exp4[i]);
      end
    end
    bad = count_bad(k, n, 32'd1, 114, 113);
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL rfc_stream bad_bytes=%0d required=0", bad);
    end
    checks++;
    if (req_ctr.size() !== 2 || req_ctr[0] !== 32'd1 || req_ctr[1] !== 32'd2) begin
      failures++;
      $display("FAIL rfc_requests count=%0d first=%h second=%h required=2,1,2", req_ctr.size(),
               (req_ctr.size() > 0) ? req_ctr[0] : 32'hx, (req_ctr.size() > 1) ? req_ctr[1] : 32'hx);
    end
    #1;
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL rfc_busy_after got=%b required=0", busy_o);
    end
  endtask

  task automatic test_backpressure;
    logic [255:0] k;
    logic [95:0]  n;
    logic [31:0]  c0 = 32'($urandom_range(0, 100000));
    int           len = $urandom_range(130, 200);
    int           nblk = (len + 63) / 64;
    int           bad;
    for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom;
    for (int j = 0; j < 3; j++) n[32*j +: 32] = $urandom;
    msg.delete();
    for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
    req_ctr.delete();
    stall_err = 0;
    rdy_err   = 0;
    do_load(k, n, c0);
    run_msg(len, len, 1'b1);
    bad = count_bad(k, n, c0, len, len - 1);
    checks++;
    if (got.size() !== len || bad !== 0) begin
      failures++;
      $display("FAIL bp_stream received=%0d bad=%0d required=%0d,0", got.size(), bad, len);
    end
    checks++;
    if (stall_err !== 0) begin
      failures++;
      $display("FAIL bp_stall_stable violations=%0d required=0", stall_err);
    end
    checks++;
    if (rdy_err !== 0) begin
      failures++;
      $display("FAIL bp_pt_ready_rule violations=%0d required=0", rdy_err);
    end
    checks++;
    if (req_ctr.size() !== nblk) begin
      failures++;
      $display("FAIL bp_req_count got=%0d required=%0d", req_ctr.size(), nblk);
    end
    for (int b = 0; b < req_ctr.size() && b < nblk; b++) begin
      checks++;
      if (req_ctr[b] !== c0 + 32'(b)) begin
        failures++;
        $display("FAIL bp_req_ctr%0d got=%h required=%h", b, req_ctr[b], c0 + 32'(b));
      end
    end
  endtask

  task automatic test_early_last;
    logic [255:0] k;
    logic [95:0]  n;
    logic [31:0]  c0 = 32'($urandom_range(10, 1000));
    int           bad;
    for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom;
    for (int j = 0; j < 3; j++) n[32*j +: 32] = $urandom;
    msg.delete();
    for (int i = 0; i < 10; i++) msg.push_back(8'($urandom));
    req_ctr.delete();
    do_load(k, n, c0);
    run_msg(5, 5, 1'b0);
    bad = count_bad(k, n, c0, 5, 4);
    checks++;
    if (got.size() !== 5 || bad !== 0) begin
      failures++;
      $display("FAIL early_stream received=%0d bad=%0d required=5,0", got.size(), bad);
    end
    #1;
    checks++;
    if (busy_o !== 1'b0 || ks_counter_o !== c0) begin
      failures++;
      $display("FAIL early_idle busy=%b ctr=%h required=0,%h", busy_o, ks_counter_o, c0);
    end
    req_ctr.delete();
    do_load(k, n, c0);
    run_msg(10, 10, 1'b0);
    bad = count_bad(k, n, c0, 10, 9);
    checks++;
    if (req_ctr.size() !== 1 || req_ctr[0] !== c0 || bad !== 0) begin
      failures++;
      $display("FAIL early_reload reqs=%0d bad=%0d required=1,0", req_ctr.size(), bad);
    end
  endtask

  task automatic test_reset_mid_fill;
    logic [255:0] k;
    logic [95:0]  n;
    logic [31:0]  c0 = 32'($urandom_range(0, 5000));
    int           cyc = 0;
    int           bad;
    for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom;
    for (int j = 0; j < 3; j++) n[32*j +: 32] = $urandom;
    gen_limit = 20;
    do_load(k, n, c0);
    while (!(gen_busy && gen_pos >= 20) && cyc < 2000) begin
      @(negedge clk_i);
      #2;
      cyc++;
    end
    checks++;
    if (cyc >= 2000) begin
      failures++;
      $display("FAIL mid_fill_wait gen_pos=%0d required=20", gen_pos);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    gen_kill = 1'b1;
    @(negedge clk_i);
    #1;
    checks++;
    if ({busy_o, ks_start_o, pt_ready_o, ct_valid_o, ct_last_o} !== 5'b0 || ct_data_o !== 8'h00 ||
        ks_counter_o !== 32'h0 || ks_key_o !== 256'h0 || ks_nonce_o !== 96'h0) begin
      failures++;
      $display("FAIL mid_fill_reset flags=%b ct=%h ctr=%h required=all zero",
               {busy_o, ks_start_o, pt_ready_o, ct_valid_o, ct_last_o}, ct_data_o, ks_counter_o);
    end
    rst_i = 1'b0;
    gen_limit = 64;
    msg.delete();
    for (int i = 0; i < 70; i++) msg.push_back(8'($urandom));
    req_ctr.delete();
    do_load(k, n, c0);
    run_msg(70, 70, 1'b0);
    bad = count_bad(k, n, c0, 70, 69);
    checks++;
    if (got.size() !== 70 || bad !== 0 || req_ctr.size() !== 2) begin
      failures++;
      $display("FAIL mid_fill_recover received=%0d bad=%0d reqs=%0d required=70,0,2",
               got.size(), bad, req_ctr.size());
    end
  endtask

  task automatic test_ctr_wrap;
    logic [255:0] k;
    logic [95:0]  n;
    int           bad;
    for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom;
    for (int j = 0; j < 3; j++) n[32*j +: 32] = $urandom;
    msg.delete();
    for (int i = 0; i < 65; i++) msg.push_back(8'($urandom));
    req_ctr.delete();
    do_load(k, n, 32'hFFFF_FFFF);
`ifdef CHACHA_CTR_GUARD_EN
    run_msg(65, 64, 1'b0);
    bad = count_bad(k, n, 32'hFFFF_FFFF, 64, -1);
    repeat (10) @(negedge clk_i);
    #1;
    checks++;
    if (got.size() !== 64 || bad !== 0) begin
      failures++;
      $display("FAIL guard_stream received=%0d bad=%0d required=64,0", got.size(), bad);
    end
    checks++;
    if (ctr_err_o !== 1'b1 || busy_o !== 1'b0 || ks_start_o !== 1'b0 || req_ctr.size() !== 1) begin
      failures++;
      $display("FAIL guard_stop err=%b busy=%b start=%b reqs=%0d required=1,0,0,1",
               ctr_err_o, busy_o, ks_start_o, req_ctr.size());
    end
    msg.delete();
    for (int i = 0; i < 3; i++) msg.push_back(8'($urandom));
    do_load(k, n, 32'd5);
    #1;
    checks++;
    if (ctr_err_o !== 1'b0) begin
      failures++;
      $display("FAIL guard_clear got=%b required=0", ctr_err_o);
    end
    run_msg(3, 3, 1'b0);
`else
    run_msg(65, 65, 1'b0);
    bad = count_bad(k, n, 32'hFFFF_FFFF, 65, 64);
    checks++;
    if (got.size() !== 65 || bad !== 0) begin
      failures++;
      $display("FAIL wrap_stream received=%0d bad=%0d required=65,0", got.size(), bad);
    end
    checks++;
    if (req_ctr.size() !== 2 || req_ctr[0] !== 32'hFFFF_FFFF || req_ctr[1] !== 32'h0) begin
      failures++;
      $display("FAIL wrap_requests count=%0d second=%h required=2,00000000", req_ctr.size(),
               (req_ctr.size() > 1) ? req_ctr[1] : 32'hx);
    end
`endif
  endtask

  initial begin
    rst_i = 1'b1; key_i = '0; nonce_i = '0; counter_init_i = '0; load_i = 1'b0;
    pt_data_i = 8'h00; pt_valid_i = 1'b0; pt_last_i = 1'b0; ct_ready_i = 1'b1;
    test_reset();
    test_rfc_vector();
    test_backpressure();
    test_early_last();
    test_reset_mid_fill();
    test_ctr_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
